// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the 1-D convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int unsigned SAT_W = 64;

  // Full-precision accumulator width for M products of two T-bit operands.
  function automatic int unsigned acc_width(input int unsigned t, input int unsigned m);
    return 2 * t + $clog2(m);
  endfunction

  // Clamp a wide signed value into the signed t-bit range.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int unsigned t);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (t - 32'd1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One multiply-accumulate lane: registered product, registered accumulator.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int unsigned T     = 11,
  parameter int unsigned ACC_W = acc_width(11, 9)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [T-1:0]     x_in,
  input  logic signed [T-1:0]     f_in,
  input  logic                    prod_en,
  input  logic                    acc_en,
  input  logic                    acc_first,
  output logic signed [ACC_W-1:0] acc_next_c
);

  localparam int unsigned PW = 2 * T;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;

  assign prod_ext   = ACC_W'(prod);
  // First tap of a group restarts the sum instead of adding to the old one.
  assign acc_next_c = acc_first ? prod_ext : acc + prod_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (prod_en) prod <= PW'(x_in) * PW'(f_in);
      if (acc_en)  acc  <= acc_next_c;
    end
  end

endmodule

// File: rtl/conv1d_param.sv
// Streaming 1-D convolution: load N x words and M taps, emit N-M+1 saturated results.
// Optional macro CONV1D_RELU_EN clamps negative results to zero.
module conv1d_param
  import conv_pkg::*;
#(
  parameter int unsigned N = 30,
  parameter int unsigned M = 9,
  parameter int unsigned T = 11,
  parameter int unsigned P = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] s_data_in_x,
  input  logic                s_valid_x,
  output logic                s_ready_x,
  input  logic signed [T-1:0] s_data_in_f,
  input  logic                s_valid_f,
  output logic                s_ready_f,
  output logic signed [T-1:0] m_data_out_y,
  output logic                m_valid_y,
  input  logic                m_ready_y
);

  localparam int unsigned NO    = N - M + 1;
  localparam int unsigned NG    = NO / P;
  localparam int unsigned ACC_W = acc_width(T, M);
  localparam int unsigned XI    = $clog2(N);
  localparam int unsigned FI    = $clog2(M);
  localparam int unsigned XCW   = $clog2(N + 1);
  localparam int unsigned FCW   = $clog2(M + 1);
  localparam int unsigned CW    = $clog2(M + 2);
  localparam int unsigned GW    = $clog2(NG + 1);
  localparam int unsigned LW    = $clog2(P + 1);

  if (M < 2 || M > N) begin : g_bad_m
    $error("conv1d_param: M must satisfy 2 <= M <= N");
  end
  if (NO % P != 0) begin : g_bad_p
    $error("conv1d_param: (N-M+1) must be a multiple of P");
  end

  state_t state, state_nxt;

  logic [XCW-1:0] x_cnt, x_cnt_nxt;
  logic [FCW-1:0] f_cnt, f_cnt_nxt;
  logic [CW-1:0]  cyc;
  logic [GW-1:0]  grp;
  logic [XI-1:0]  base;
  logic [LW-1:0]  left;
  logic           x_fire, f_fire, issue, prod_en, acc_en, acc_first;
  logic           last_tap, out_fire, group_done, last_group;
  logic           ready_x_nxt, ready_f_nxt;

  logic signed [T-1:0]     x_mem     [N];
  logic signed [T-1:0]     f_mem     [M];
  logic signed [T-1:0]     x_rd      [P];
  logic signed [T-1:0]     f_rd;
  logic signed [T-1:0]     res       [P];
  logic signed [T-1:0]     res_new   [P];
  logic signed [T-1:0]     res_shift [P];
  logic signed [ACC_W-1:0] acc_next  [P];

  // Saturate, then optionally rectify, one lane result.
  function automatic logic signed [T-1:0] finish_result(input logic signed [ACC_W-1:0] a);
    logic signed [T-1:0] s;
    s = T'(saturate(SAT_W'(a), T));
`ifdef CONV1D_RELU_EN
    if (s[T-1]) s = '0;
`endif
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  // Next state plus pipeline control. cyc counts cycles since COMPUTE entry:
  // read at cyc, product at cyc+1, accumulate at cyc+2.
  always_comb begin
    state_nxt   = state;
    x_fire      = s_valid_x && s_ready_x;
    f_fire      = s_valid_f && s_ready_f;
    issue       = 1'b0;
    prod_en     = 1'b0;
    acc_en      = 1'b0;
    acc_first   = 1'b0;
    last_tap    = 1'b0;
    out_fire    = 1'b0;
    group_done  = 1'b0;
    last_group  = (grp == GW'(NG - 1));
    x_cnt_nxt   = x_cnt;
    f_cnt_nxt   = f_cnt;
    ready_x_nxt = 1'b0;
    ready_f_nxt = 1'b0;
    case (state)
      LOAD: begin
        if (x_cnt == XCW'(N) && f_cnt == FCW'(M)) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        issue     = (cyc < CW'(M));
        prod_en   = (cyc != '0) && (cyc <= CW'(M));
        acc_en    = (cyc >= CW'(2));
        acc_first = (cyc == CW'(2));
        if (cyc == CW'(M + 1)) begin
          last_tap  = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        out_fire = m_valid_y && m_ready_y;
        if (out_fire && left == LW'(1)) begin
          group_done = 1'b1;
          state_nxt  = last_group ? LOAD : COMPUTE;
        end
      end
      default: state_nxt = LOAD;
    endcase
    if (group_done && last_group) begin
      x_cnt_nxt = '0;
      f_cnt_nxt = '0;
    end else begin
      if (x_fire) x_cnt_nxt = x_cnt + XCW'(1);
      if (f_fire) f_cnt_nxt = f_cnt + FCW'(1);
    end
    ready_x_nxt = (state_nxt == LOAD) && (x_cnt_nxt < XCW'(N));
    ready_f_nxt = (state_nxt == LOAD) && (f_cnt_nxt < FCW'(M));
  end

  // Group result buffer: capture on last tap, shift toward the head on accept.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      res_new[i]   = finish_result(acc_next[i]);
      res_shift[i] = '0;
    end
    for (int i = 0; i + 1 < P; i++) res_shift[i] = res[i + 1];
  end

  always_ff @(posedge clk) begin
    if (x_fire) x_mem[XI'(x_cnt)] <= s_data_in_x;
    if (f_fire) f_mem[FI'(f_cnt)] <= s_data_in_f;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt        <= '0;
      f_cnt        <= '0;
      s_ready_x    <= 1'b1;
      s_ready_f    <= 1'b1;
      cyc          <= '0;
      grp          <= '0;
      base         <= '0;
      left         <= '0;
      m_valid_y    <= 1'b0;
      m_data_out_y <= '0;
      f_rd         <= '0;
      for (int l = 0; l < P; l++) begin
        x_rd[l] <= '0;
        res[l]  <= '0;
      end
    end else begin
      x_cnt     <= x_cnt_nxt;
      f_cnt     <= f_cnt_nxt;
      s_ready_x <= ready_x_nxt;
      s_ready_f <= ready_f_nxt;
      cyc       <= (state == COMPUTE && state_nxt == COMPUTE) ? cyc + CW'(1) : '0;
      if (issue) begin
        f_rd <= f_mem[FI'(cyc)];
        for (int l = 0; l < P; l++) x_rd[l] <= x_mem[base + XI'(l) + XI'(cyc)];
      end
      if (last_tap) begin
        res          <= res_new;
        m_data_out_y <= res_new[0];
        m_valid_y    <= 1'b1;
        left         <= LW'(P);
      end else if (out_fire) begin
        res          <= res_shift;
        m_data_out_y <= res_shift[0];
        left         <= left - LW'(1);
        if (group_done) begin
          m_valid_y <= 1'b0;
          if (last_group) begin
            grp  <= '0;
            base <= '0;
          end else begin
            grp  <= grp + GW'(1);
            base <= base + XI'(P);
          end
        end
      end
    end
  end

  for (genvar l = 0; l < P; l++) begin : g_lane
    conv_mac_lane #(
      .T    (T),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .x_in      (x_rd[l]),
      .f_in      (f_rd),
      .prod_en   (prod_en),
      .acc_en    (acc_en),
      .acc_first (acc_first),
      .acc_next_c(acc_next[l])
    );
  end

endmodule

// File: tb/tb_conv1d_param.sv
// Self-checking bench for conv1d_param (N=8, M=3, T=8, P=2): table vectors plus random jobs.
module tb_conv1d_param;

  localparam int N  = 8;
  localparam int M  = 3;
  localparam int T  = 8;
  localparam int P  = 2;
  localparam int NO = N - M + 1;

  typedef logic signed [T-1:0] xv_t [N];
  typedef logic signed [T-1:0] fv_t [M];
  typedef logic signed [T-1:0] yv_t [NO];

  typedef struct {
    xv_t   x;
    fv_t   f;
    yv_t   y;
    int    mode;
    int    rdy_pct;
    bit    chk_lat;
    string name;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset;
  logic signed [T-1:0] s_data_in_x, s_data_in_f, m_data_out_y;
  logic                s_valid_x, s_ready_x, s_valid_f, s_ready_f, m_valid_y, m_ready_y;

  int  checks = 0;
  int  failures = 0;
  int  cyc_cnt = 0;
  int  last_edge = 0;
  xv_t cur_x;
  fv_t cur_f;
  vec_t vecs [7];

  conv1d_param #(.N(N), .M(M), .T(T), .P(P)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data_in_x (s_data_in_x),
    .s_valid_x   (s_valid_x),
    .s_ready_x   (s_ready_x),
    .s_data_in_f (s_data_in_f),
    .s_valid_f   (s_valid_f),
    .s_ready_f   (s_ready_f),
    .m_data_out_y(m_data_out_y),
    .m_valid_y   (m_valid_y),
    .m_ready_y   (m_ready_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Direct evaluation of the convolution sum with saturation.
  function automatic void model(input xv_t x, input fv_t f, output yv_t y);
    for (int i = 0; i < NO; i++) begin
      int s = 0;
      for (int j = 0; j < M; j++) s += int'(x[i + j]) * int'(f[j]);
      if (s > 127) s = 127;
      if (s < -128) s = -128;
`ifdef CONV1D_RELU_EN
      if (s < 0) s = 0;
`endif
      y[i] = 8'(s);
    end
  endfunction

  // mode 0: both streams back-to-back; 1: all f first; 2: random gaps, junk held after count.
  task automatic drive_inputs(input int mode, input string tag);
    int xi = 0, fi = 0, guard = 0;
    bit vx, vf;
    while ((xi < N || fi < M) && guard < 500) begin
      @(negedge clk);
      guard++;
      check({tag, "_ready_x"}, int'(s_ready_x), int'(xi < N));
      check({tag, "_ready_f"}, int'(s_ready_f), int'(fi < M));
      case (mode)
        1:       begin vf = (fi < M); vx = (fi == M) && (xi < N); end
        2:       begin vx = 1'($urandom_range(1)); vf = 1'($urandom_range(1)); end
        default: begin vx = (xi < N); vf = (fi < M); end
      endcase
      s_valid_x   = vx;
      s_valid_f   = vf;
      s_data_in_x = (xi < N) ? cur_x[xi] : 8'sh55;
      s_data_in_f = (fi < M) ? cur_f[fi] : 8'sh2a;
      if (vx && s_ready_x) xi++;
      if (vf && s_ready_f) fi++;
      if (xi == N && fi == M) last_edge = cyc_cnt + 1;
    end
    if (xi < N || fi < M) check({tag, "_load_timeout"}, xi + fi, N + M);
    @(negedge clk);
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    check({tag, "_ready_x_done"}, int'(s_ready_x), 0);
    check({tag, "_ready_f_done"}, int'(s_ready_f), 0);
  endtask

  task automatic collect(input yv_t exp, input int pct, input bit chk_lat, input string tag);
    int k = 0, guard = 0, extra = 0;
    bit seen = 1'b0, r;
    while (k < NO && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (m_valid_y) begin
        if (!seen) begin
          seen = 1'b1;
          if (chk_lat) check({tag, "_latency"}, cyc_cnt - last_edge, M + 3);
        end
        check($sformatf("%s_y%0d", tag, k), int'(m_data_out_y), int'(exp[k]));
      end
      r = ($urandom_range(99) < pct);
      m_ready_y = r;
      if (m_valid_y && r) k++;
    end
    if (k < NO) check({tag, "_out_timeout"}, k, NO);
    repeat (10) begin
      @(negedge clk);
      m_ready_y = 1'b1;
      if (m_valid_y) extra++;
    end
    check({tag, "_extra_outputs"}, extra, 0);
    check({tag, "_idle_ready_x"}, int'(s_ready_x), 1);
    check({tag, "_idle_ready_f"}, int'(s_ready_f), 1);
  endtask

  initial begin
    xv_t ramp;
    yv_t ry;
    reset = 1'b1;
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    s_data_in_x = '0;
    s_data_in_f = '0;
    m_ready_y = 1'b0;

    @(negedge clk);
    check("rst_ready_x", int'(s_ready_x), 1);
    check("rst_ready_f", int'(s_ready_f), 1);
    check("rst_valid_y", int'(m_valid_y), 0);
    check("rst_data_y", int'(m_data_out_y), 0);
    @(negedge clk);
    reset = 1'b0;

    ramp = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
    ry   = '{8'sd6, 8'sd9, 8'sd12, 8'sd15, 8'sd18, 8'sd21};

    vecs[0] = '{x: ramp, f: '{default: 8'sd1}, y: ry, mode: 0, rdy_pct: 100, chk_lat: 1'b1, name: "ramp"};
    vecs[1] = '{x: '{default: 8'sd127}, f: '{default: 8'sd127}, y: '{default: 8'sd127},
                mode: 0, rdy_pct: 100, chk_lat: 1'b1, name: "sat_pos"};
`ifdef CONV1D_RELU_EN
    vecs[2] = '{x: '{default: -8'sd128}, f: '{default: 8'sd127}, y: '{default: 8'sd0},
                mode: 0, rdy_pct: 100, chk_lat: 1'b0, name: "sat_neg"};
`else
    vecs[2] = '{x: '{default: -8'sd128}, f: '{default: 8'sd127}, y: '{default: -8'sd128},
                mode: 0, rdy_pct: 100, chk_lat: 1'b0, name: "sat_neg"};
`endif
    vecs[3] = '{x: ramp, f: '{default: 8'sd1}, y: ry, mode: 0, rdy_pct: 50, chk_lat: 1'b0, name: "backpressure"};
    vecs[4] = '{x: ramp, f: '{default: 8'sd1}, y: ry, mode: 1, rdy_pct: 100, chk_lat: 1'b1, name: "f_first"};
    vecs[5] = '{x: ramp, f: '{default: 8'sd1}, y: ry, mode: 2, rdy_pct: 100, chk_lat: 1'b1, name: "gaps"};
`ifdef CONV1D_RELU_EN
    vecs[6] = '{x: ramp, f: '{8'sd1, 8'sd0, -8'sd1}, y: '{default: 8'sd0},
                mode: 0, rdy_pct: 100, chk_lat: 1'b1, name: "post_reset"};
`else
    vecs[6] = '{x: ramp, f: '{8'sd1, 8'sd0, -8'sd1}, y: '{default: -8'sd2},
                mode: 0, rdy_pct: 100, chk_lat: 1'b1, name: "post_reset"};
`endif

    for (int v = 0; v < 6; v++) begin
      cur_x = vecs[v].x;
      cur_f = vecs[v].f;
      drive_inputs(vecs[v].mode, vecs[v].name);
      collect(vecs[v].y, vecs[v].rdy_pct, vecs[v].chk_lat, vecs[v].name);
    end

    // Abort a job in COMPUTE, then confirm the following job is clean.
    for (int i = 0; i < N; i++) cur_x[i] = 8'($urandom);
    for (int j = 0; j < M; j++) cur_f[j] = 8'($urandom);
    drive_inputs(0, "abort");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_valid_y", int'(m_valid_y), 0);
    check("abort_ready_x", int'(s_ready_x), 1);
    check("abort_ready_f", int'(s_ready_f), 1);
    reset = 1'b0;
    cur_x = vecs[6].x;
    cur_f = vecs[6].f;
    drive_inputs(vecs[6].mode, vecs[6].name);
    collect(vecs[6].y, vecs[6].rdy_pct, vecs[6].chk_lat, vecs[6].name);

    for (int r = 0; r < 6; r++) begin
      yv_t ey;
      int pct;
      for (int i = 0; i < N; i++) cur_x[i] = 8'($urandom);
      for (int j = 0; j < M; j++) cur_f[j] = 8'($urandom_range(40) - 20);
      if (r == 5) for (int j = 0; j < M; j++) cur_f[j] = 8'($urandom);
      model(cur_x, cur_f, ey);
      pct = (r % 2 == 0) ? 100 : 40;
      drive_inputs(r % 3, $sformatf("rand%0d", r));
      collect(ey, pct, pct == 100, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
